// File: rtl/ucdp_clk_div.sv
// Integer clock divider: clk_o runs at clk_i / (div_i + 2) with a ceil(N/2) high phase.
// Periods always run to completion once started; only reset truncates one.
//
// state | meaning
// IDLE  | no period in progress, outputs low, waiting for en_i
// RUN   | divided-clock period in progress, cnt counts 0..n-1
module ucdp_clk_div #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_an_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             active_o
);

  localparam int unsigned CW = WIDTH + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   n;
  logic [CW-1:0]   cnt_inc;
  logic [CW-1:0]   n_load;
  logic [CW:0]     h_wide;
  logic            period_end;

  assign cnt_inc    = cnt + CW'(1);
  assign n_load     = {1'b0, div_i} + CW'(2);
  assign period_end = (cnt == (n - CW'(1)));
  // One extra bit so n = 2^WIDTH+1 rounds up without wrapping.
  assign h_wide     = ({1'b0, n} + (CW + 1)'(1)) >> 1;

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state    <= IDLE;
      cnt      <= '0;
      n        <= CW'(2);
      clk_o    <= 1'b0;
      tick_o   <= 1'b0;
      active_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (en_i) begin
            n        <= n_load;
            clk_o    <= 1'b1;
            tick_o   <= 1'b1;
            active_o <= 1'b1;
            state    <= RUN;
          end else begin
            clk_o    <= 1'b0;
            tick_o   <= 1'b0;
            active_o <= 1'b0;
          end
        end
        RUN: begin
          if (!period_end) begin
            cnt    <= cnt_inc;
            clk_o  <= ({1'b0, cnt_inc} < h_wide);
            tick_o <= 1'b0;
          end else if (en_i) begin
            n      <= n_load;
            cnt    <= '0;
            clk_o  <= 1'b1;
            tick_o <= 1'b1;
          end else begin
            cnt      <= '0;
            clk_o    <= 1'b0;
            tick_o   <= 1'b0;
            active_o <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef SIM
  always @(posedge clk_i) begin
    if (rst_an_i && (state == IDLE || period_end) && $isunknown({en_i, div_i}))
      $display("SIMERROR ucdp_clk_div: en_i/div_i unknown at period start");
  end
`endif

endmodule

// File: tb/tb_ucdp_clk_div.sv
// Directed bench for ucdp_clk_div: a cycle model pushes the expected
// {clk_o, tick_o, active_o} for each edge, popped and compared after the edge.
module tb_ucdp_clk_div;

  logic       clk_i = 1'b0;
  logic       rst_an_i;
  logic       en_i;
  logic [3:0] div_i;
  logic       clk_o;
  logic       tick_o;
  logic       active_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] sb[$];

  // reference model
  bit m_run = 1'b0;
  int m_pos = 0;
  int m_n   = 2;

  logic last_clk;

  ucdp_clk_div #(.WIDTH(4)) dut (
    .clk_i    (clk_i),
    .rst_an_i (rst_an_i),
    .en_i     (en_i),
    .div_i    (div_i),
    .clk_o    (clk_o),
    .tick_o   (tick_o),
    .active_o (active_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_step(input logic en, input logic [3:0] div);
    logic [2:0] e;
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_n   = int'(div) + 2;
        m_pos = 0;
        e     = 3'b111;
      end else begin
        e = 3'b000;
      end
    end else if (m_pos < m_n - 1) begin
      m_pos++;
      e = {(m_pos < (m_n + 1) / 2), 1'b0, 1'b1};
    end else if (en) begin
      m_n   = int'(div) + 2;
      m_pos = 0;
      e     = 3'b111;
    end else begin
      m_run = 1'b0;
      m_pos = 0;
      e     = 3'b000;
    end
    return e;
  endfunction

  task automatic cycle(input string tag, input logic en, input logic [3:0] div);
    logic [2:0] e;
    @(negedge clk_i);
    en_i  = en;
    div_i = div;
    sb.push_back(model_step(en, div));
    @(posedge clk_i);
    #1;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      assert ({clk_o, tick_o, active_o} === e) else begin
        n_fail++;
        $error("FAIL %s: observed clk/tick/active %b expected %b", tag,
               {clk_o, tick_o, active_o}, e);
      end
    end
    last_clk = clk_o;
  endtask

  initial begin
    int highs;
    int ticks;
    rst_an_i = 1'b0;
    en_i     = 1'b0;
    div_i    = 4'd0;
    #2;
    check("reset_outputs", {29'd0, clk_o, tick_o, active_o}, 32'd0);
    #21;
    rst_an_i = 1'b1;

    cycle("idle", 1'b0, 4'd0);
    cycle("idle", 1'b0, 4'd0);

    // N=2 continuous run
    for (int i = 0; i < 10; i++) cycle("n2_run", 1'b1, 4'd0);
    cycle("n2_stop", 1'b0, 4'd0);
    cycle("n2_stop", 1'b0, 4'd0);

    // N=5 continuous, then en dropped at cnt=1 of the third period
    ticks = 0;
    for (int i = 0; i < 11; i++) begin
      cycle("n5_run", 1'b1, 4'd3);
      ticks += int'(tick_o);
    end
    check("n5_tick_count", ticks, 32'd3);
    for (int i = 0; i < 6; i++) cycle("n5_drop", 1'b0, 4'd3);

    // N=3 period with div changed to 0 mid-period
    cycle("n3_start", 1'b1, 4'd1);
    for (int i = 0; i < 5; i++) cycle("n3_then_n2", 1'b1, 4'd0);
    for (int i = 0; i < 3; i++) cycle("n2_end", 1'b0, 4'd0);

    // N=17, maximum ratio
    highs = 0;
    cycle("n17_start", 1'b1, 4'd15);
    highs += int'(last_clk);
    for (int i = 0; i < 16; i++) begin
      cycle("n17_run", 1'b0, 4'd15);
      highs += int'(last_clk);
    end
    check("n17_high_cycles", highs, 32'd9);
    cycle("n17_end", 1'b0, 4'd15);

    // async reset during high phase
    cycle("rst_start", 1'b1, 4'd3);
    cycle("rst_high", 1'b1, 4'd3);
    #2;
    rst_an_i = 1'b0;
    en_i     = 1'b0;
    #1;
    check("async_rst_clk", {31'd0, clk_o}, 32'd0);
    check("async_rst_tick_active", {30'd0, tick_o, active_o}, 32'd0);
    m_run = 1'b0;
    m_pos = 0;
    rst_an_i = 1'b1;
    cycle("post_rst_start", 1'b1, 4'd3);
    for (int i = 0; i < 6; i++) cycle("post_rst_run", 1'b0, 4'd3);

    // randomized mix
    for (int i = 0; i < 60; i++)
      cycle("random", 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ucdp_clk_div.md
UCDP_CLK_DIV -- requirements
Module: ucdp_clk_div

Interface
REQ-001 Parameter: WIDTH, default 4, width of the divider ratio input; legal range 1..16.
REQ-002 Port: clk_i  input  1  source clock; the only clock of the block; all state changes on its rising edge.
REQ-003 Port: rst_an_i  input  1  reset, asynchronous, active-low; deassertion is synchronized to clk_i outside this block.
REQ-004 Port: en_i  input  1  run request; level-sensitive, sampled on the rising edge of clk_i.
REQ-005 Port: div_i  input  WIDTH  ratio select; division ratio N = div_i + 2 (range 2..2^WIDTH+1).
REQ-006 Port: clk_o  output  1  divided clock, driven directly from a flop; feeds ucdp_clk_or inputs clka_i/clkb_i.
REQ-007 Port: tick_o  output  1  one-clk_i-cycle pulse, high in the clk_i cycle in which clk_o rises.
REQ-008 Port: active_o  output  1  high while a divided-clock period is in progress.

Function
REQ-009 The block SHALL hold: state (IDLE, RUN), counter cnt (WIDTH+1 bits), latched ratio n (WIDTH+1 bits), and registered clk_o, tick_o, active_o.
REQ-010 High time H SHALL be ceil(n/2) clk_i cycles and low time n-H cycles; for example N=2: 1/1, N=3: 2/1, N=5: 3/2.
REQ-011 IDLE, en_i=0: all outputs SHALL be 0 and cnt SHALL be 0.
REQ-012 IDLE, en_i=1 at an edge: the block SHALL load n=div_i+2, set cnt=0, clk_o=1, tick_o=1, active_o=1, and enter RUN, so clk_o rises on the first edge at which en_i is sampled high.
REQ-013 RUN, cnt < n-1: the block SHALL set cnt=cnt+1, clk_o=(cnt+1 < H), and tick_o=0.
REQ-014 RUN, cnt == n-1 (period end), en_i=1: the block SHALL reload n=div_i+2, set cnt=0, clk_o=1, and tick_o=1, giving back-to-back periods with no gap.
REQ-015 RUN, cnt == n-1, en_i=0: the block SHALL set clk_o=0, tick_o=0, active_o=0, cnt=0, and enter IDLE.
REQ-016 Deassertion of en_i mid-period SHALL NOT truncate the period; the period completes and clk_o ends low.
REQ-017 div_i SHALL be sampled only at period start (REQ-012 and REQ-014); changes mid-period SHALL have no effect until the next period.
REQ-018 clk_o SHALL be glitch-free, with no combinational path from any input to clk_o, and each high and low phase SHALL be a whole number of clk_i cycles.
REQ-019 The counter width SHALL represent 2^WIDTH without overflow; no wrap-around SHALL occur within a period.
REQ-020 The maximum div_i value (all ones) SHALL give N = 2^WIDTH+1 with correct H (2^(WIDTH-1)+1 for WIDTH>=1).
REQ-021 In a SIM build only, the block SHALL print one SIMERROR line if en_i or div_i is X/Z when sampled at a period start.

Reset
REQ-022 When rst_an_i=0, the block SHALL immediately, independent of clk_i, force state=IDLE, cnt=0, n=2, clk_o=0, tick_o=0, and active_o=0.
REQ-023 Reset mid-period SHALL truncate the period; clk_o goes low asynchronously, which is permitted (downstream is in reset too).
REQ-024 After reset release, the first rising edge of clk_o SHALL occur no earlier than the first clk_i edge at which en_i is sampled high.

Verification
REQ-025 Scenario: WIDTH=4, div_i=0, en_i=1 for 10 clk_i cycles -> clk_o toggles 1,0,1,0...; tick_o high on cycles 1,3,5...; active_o=1 throughout.
REQ-026 Scenario: div_i=3 (N=5), en_i=1 -> clk_o pattern 1,1,1,0,0 repeating; tick_o pulse every 5 cycles.
REQ-027 Scenario: N=5 run, en_i dropped at cnt=1 -> clk_o completes 1,1,1,0,0; active_o falls at the edge after cnt=4; no further ticks.
REQ-028 Scenario: div_i changed 1->0 at cnt=1 of an N=3 period -> current period stays 1,1,0; the next period is 1,0.
REQ-029 Scenario: div_i=15 (N=17) -> 9 cycles high, 8 cycles low; no counter overflow.
REQ-030 Scenario: rst_an_i pulsed low mid-high-phase -> clk_o, tick_o, active_o go 0 without a clk_i edge; after release with en_i=1, clk_o rises on the first sampling edge.
